// File: rtl/sdram_pkg.sv
// Shared SDRAM region map and controller state encoding.
// The writer and the reader both use it, so region geometry is defined here only.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [31:0] IMG_OFFSET = 32'h0000_0000;
    localparam logic [31:0] L0_OFFSET  = 32'h0000_0080;
    localparam logic [31:0] L1_OFFSET  = 32'h0000_0880;
    localparam logic [31:0] L2_OFFSET  = 32'h0000_0980;

    localparam logic [11:0] IMG_SIZE = 12'd128;
    localparam logic [11:0] L0_SIZE  = 12'd2048;
    localparam logic [11:0] L1_SIZE  = 12'd256;
    localparam logic [11:0] L2_SIZE  = 12'd160;

    // Region select encoding: 00 L0, 01 L1, 10 L2, 11 image.
    function automatic logic [31:0] region_offset(input logic [1:0] sel);
        case (sel)
            2'b00:   return L0_OFFSET;
            2'b01:   return L1_OFFSET;
            2'b10:   return L2_OFFSET;
            default: return IMG_OFFSET;
        endcase
    endfunction

    function automatic logic [11:0] region_size(input logic [1:0] sel);
        case (sel)
            2'b00:   return L0_SIZE;
            2'b01:   return L1_SIZE;
            2'b10:   return L2_SIZE;
            default: return IMG_SIZE;
        endcase
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO buffering source bytes ahead of the Avalon write port.
// Registered push (no bypass); push ignored when full, pop ignored when empty.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = do_push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = do_pop  ? rptr_q + PTR_ONE : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/sdram_writer.sv
// Streams one SDRAM region (image/L0/L1/L2) from a byte source to an Avalon write master.
// One cycle from byte acceptance to earliest write; in_ready drops when the buffer is full or the region is fully accepted.
module sdram_writer
    import sdram_pkg::*;
#(
    parameter int          MASTER_ADDRESSWIDTH = 28,
    parameter int          DATAWIDTH           = 8,
    parameter logic [31:0] SDRAM_ADDR          = 32'h0800_0000,
    parameter int          FIFO_DEPTH          = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     which_data,
    input  logic [DATAWIDTH-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           busy,
    output logic                           done,
    output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0]           master_writedata,
    output logic                           master_write,
    output logic                           master_read,
    input  logic                           master_waitrequest
);

    state_t                         state_q, state_d;
    logic [MASTER_ADDRESSWIDTH-1:0] base_q, base_d;
    logic [11:0]                    len_q, len_d;
    logic [11:0]                    acc_q, acc_d;
    logic [11:0]                    wr_q, wr_d;

    logic                 fifo_full, fifo_empty;
    logic [DATAWIDTH-1:0] fifo_head;
    logic                 push, pop;

    assign master_read = 1'b0;

    byte_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_WRITE;
            ST_WRITE: if (wr_q == len_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready         = 1'b0;
        master_write     = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state_q)
            ST_WRITE: begin
                busy         = 1'b1;
                in_ready     = !fifo_full && (acc_q < len_q);
                master_write = !fifo_empty;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
        // Outputs derive only from registered state, so they hold across a stall.
        if (master_write) begin
            master_address   = base_q + MASTER_ADDRESSWIDTH'(wr_q);
            master_writedata = fifo_head;
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = master_write && !master_waitrequest;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        acc_d  = acc_q;
        wr_d   = wr_q;
        if (state_q == ST_IDLE && start) begin
            base_d = MASTER_ADDRESSWIDTH'(SDRAM_ADDR + region_offset(which_data));
            len_d  = region_size(which_data);
            acc_d  = '0;
            wr_d   = '0;
        end else begin
            if (push) acc_d = acc_q + 12'd1;
            if (pop)  wr_d  = wr_q + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            acc_q  <= '0;
            wr_q   <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            acc_q  <= acc_d;
            wr_q   <= wr_d;
        end
    end

endmodule

// File: tb/tb_sdram_writer.sv
// Randomized bench for sdram_writer: a region-level model predicts every Avalon write.
module tb_sdram_writer;

    localparam int MAX_CYC = 12000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  which_data;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [27:0] master_address;
    logic [7:0]  master_writedata;
    logic        master_write;
    logic        master_read;
    logic        master_waitrequest;

    int n_vec = 0;
    int n_bad = 0;

    logic [27:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic [7:0]  offer_q[$];
    int          done_cnt, accepted, stall_viol, ready_viol, hold_acc;
    logic        hold_rdy, busy_after, rst_mw, rst_busy;
    bit          timeout;

    sdram_writer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .which_data         (which_data),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .busy               (busy),
        .done               (done),
        .master_address     (master_address),
        .master_writedata   (master_writedata),
        .master_write       (master_write),
        .master_read        (master_read),
        .master_waitrequest (master_waitrequest)
    );

    always #5 clk = ~clk;

    function automatic int ref_len(input logic [1:0] w);
        case (w)
            2'b00:   return 2048;
            2'b01:   return 256;
            2'b10:   return 160;
            default: return 128;
        endcase
    endfunction

    function automatic logic [27:0] ref_base(input logic [1:0] w);
        case (w)
            2'b00:   return 28'h800_0080;
            2'b01:   return 28'h800_0880;
            2'b10:   return 28'h800_0980;
            default: return 28'h800_0000;
        endcase
    endfunction

    // wmode: 0 never stall, 1 toggle, 2 random, 3 hold high for the first 10 write cycles.
    task automatic run_region(input logic [1:0] w, input int n_offer, input int wmode,
                              input int vmode, input bit idx_data,
                              input int inject_at, input int abort_at);
        int len, hold, post;
        bit seen_done, prev_stall, injected, fin;
        logic [27:0] pa;
        logic [7:0]  pd;
        log_addr.delete(); log_data.delete(); offer_q.delete();
        done_cnt = 0; accepted = 0; stall_viol = 0; ready_viol = 0; hold_acc = -1;
        hold_rdy = 1'b1; busy_after = 1'b1; rst_mw = 1'b1; rst_busy = 1'b1; timeout = 0;
        len = ref_len(w); hold = 0; post = 0; seen_done = 0; prev_stall = 0;
        injected = 0; fin = 0; pa = '0; pd = '0;
        for (int i = 0; i < n_offer; i++)
            offer_q.push_back(idx_data ? 8'(i) : 8'($urandom));
        @(posedge clk); #1;
        for (int cyc = 0; cyc < MAX_CYC && !fin; cyc++) begin
            start      = (cyc == 0);
            which_data = w;
            if (inject_at >= 0 && !injected && log_addr.size() == inject_at) begin
                start = 1'b1; which_data = 2'b11; injected = 1;
            end
            in_valid = (accepted < n_offer) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_data  = in_valid ? offer_q[accepted] : 8'($urandom);
            case (wmode)
                0:       master_waitrequest = 1'b0;
                1:       master_waitrequest = (cyc % 2) == 1;
                2:       master_waitrequest = ($urandom_range(0, 2) == 0);
                default: master_waitrequest = (hold < 10);
            endcase
            if (abort_at >= 0 && log_addr.size() == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                rst_mw = master_write; rst_busy = busy; reset = 1'b0; fin = 1;
            end else begin
                #1;
                if (prev_stall && !(master_write && master_address == pa && master_writedata == pd))
                    stall_viol++;
                prev_stall = master_write && master_waitrequest;
                pa = master_address; pd = master_writedata;
                if (master_write && !master_waitrequest) begin
                    log_addr.push_back(master_address);
                    log_data.push_back(master_writedata);
                end
                if (in_ready && accepted >= len) ready_viol++;
                if (in_valid && in_ready) accepted++;
                if (wmode == 3 && master_write && hold < 10) begin
                    hold++;
                    if (hold == 10) begin hold_acc = accepted; hold_rdy = in_ready; end
                end
                if (done) begin done_cnt++; seen_done = 1; end
                if (seen_done) begin
                    if (post == 1) begin busy_after = busy; fin = 1; end
                    post++;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0; in_valid = 1'b0; master_waitrequest = 1'b0; which_data = 2'b00;
        if (!fin) timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; which_data = 2'b00; in_data = 8'h00;
        in_valid = 1'b1; master_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (master_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b want 0", master_write); end
        n_vec++; if (master_address !== 28'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", master_address); end
        n_vec++; if (master_writedata !== 8'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", master_writedata); end
        n_vec++; if (master_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %b want 0", master_read); end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_image();
        run_region(2'b11, 128, 0, 0, 1'b1, -1, -1);
        n_vec++; if (timeout) begin n_bad++; $display("FAIL image_timeout: got no done within %0d cycles, want done", MAX_CYC); end
        n_vec++; if (log_addr.size() != 128) begin n_bad++; $display("FAIL image_count: got %0d writes want 128", log_addr.size()); end
        for (int i = 0; i < log_addr.size() && i < 128; i++) begin
            n_vec++;
            if (log_addr[i] !== 28'h800_0000 + 28'(i) || log_data[i] !== 8'(i)) begin
                n_bad++;
                $display("FAIL image_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 28'h800_0000 + 28'(i), 8'(i));
            end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL image_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL image_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_l2_toggle();
        run_region(2'b10, 160, 1, 1, 1'b0, -1, -1);
        n_vec++; if (timeout) begin n_bad++; $display("FAIL l2_timeout: got no done within %0d cycles, want done", MAX_CYC); end
        n_vec++; if (log_addr.size() != 160) begin n_bad++; $display("FAIL l2_count: got %0d writes want 160", log_addr.size()); end
        for (int i = 0; i < log_addr.size() && i < 160; i++) begin
            n_vec++;
            if (log_addr[i] !== ref_base(2'b10) + 28'(i) || log_data[i] !== offer_q[i]) begin
                n_bad++;
                $display("FAIL l2_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], ref_base(2'b10) + 28'(i), offer_q[i]);
            end
        end
        n_vec++; if (stall_viol != 0) begin n_bad++; $display("FAIL l2_stall_stable: got %0d changes during stall want 0", stall_viol); end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL l2_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_l0_stall();
        run_region(2'b00, 2048, 3, 0, 1'b0, -1, -1);
        n_vec++; if (timeout) begin n_bad++; $display("FAIL l0_timeout: got no done within %0d cycles, want done", MAX_CYC); end
        n_vec++; if (hold_acc != 4) begin n_bad++; $display("FAIL l0_buffered: got %0d bytes during stall want 4", hold_acc); end
        n_vec++; if (hold_rdy !== 1'b0) begin n_bad++; $display("FAIL l0_ready_full: got %b want 0", hold_rdy); end
        n_vec++; if (log_addr.size() != 2048) begin n_bad++; $display("FAIL l0_count: got %0d writes want 2048", log_addr.size()); end
        for (int i = 0; i < log_addr.size() && i < 2048; i++) begin
            n_vec++;
            if (log_addr[i] !== ref_base(2'b00) + 28'(i) || log_data[i] !== offer_q[i]) begin
                n_bad++;
                $display("FAIL l0_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], ref_base(2'b00) + 28'(i), offer_q[i]);
            end
        end
        n_vec++; if (stall_viol != 0) begin n_bad++; $display("FAIL l0_stall_stable: got %0d changes during stall want 0", stall_viol); end
    endtask

    task automatic test_l1_overflow();
        run_region(2'b01, 300, 2, 0, 1'b0, -1, -1);
        n_vec++; if (timeout) begin n_bad++; $display("FAIL l1_timeout: got no done within %0d cycles, want done", MAX_CYC); end
        n_vec++; if (accepted != 256) begin n_bad++; $display("FAIL l1_accepted: got %0d want 256", accepted); end
        n_vec++; if (ready_viol != 0) begin n_bad++; $display("FAIL l1_ready_after_256: got %0d ready cycles want 0", ready_viol); end
        n_vec++; if (log_addr.size() != 256) begin n_bad++; $display("FAIL l1_count: got %0d writes want 256", log_addr.size()); end
        for (int i = 0; i < log_addr.size() && i < 256; i++) begin
            n_vec++;
            if (log_addr[i] !== ref_base(2'b01) + 28'(i) || log_data[i] !== offer_q[i]) begin
                n_bad++;
                $display("FAIL l1_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], ref_base(2'b01) + 28'(i), offer_q[i]);
            end
        end
        if (log_addr.size() > 0) begin
            n_vec++;
            if (log_addr[log_addr.size()-1] !== 28'h800_097F) begin
                n_bad++; $display("FAIL l1_last_addr: got %h want 800097f", log_addr[log_addr.size()-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        run_region(2'b00, 2048, 2, 0, 1'b0, -1, 1000);
        n_vec++; if (rst_mw !== 1'b0) begin n_bad++; $display("FAIL rstmid_write: got %b want 0", rst_mw); end
        n_vec++; if (rst_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", rst_busy); end
        n_vec++; if (log_addr.size() != 1000) begin n_bad++; $display("FAIL rstmid_count: got %0d writes want 1000", log_addr.size()); end
        extra = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (master_write) extra++;
        end
        in_valid = 1'b0;
        n_vec++; if (extra != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d write cycles want 0", extra); end
        run_region(2'b01, 256, 0, 1, 1'b0, -1, -1);
        n_vec++; if (log_addr.size() != 256) begin n_bad++; $display("FAIL rstmid_l1_count: got %0d writes want 256", log_addr.size()); end
        if (log_addr.size() > 0) begin
            n_vec++;
            if (log_addr[0] !== 28'h800_0880) begin n_bad++; $display("FAIL rstmid_l1_first: got %h want 8000880", log_addr[0]); end
        end
        for (int i = 0; i < log_addr.size() && i < 256; i++) begin
            n_vec++;
            if (log_addr[i] !== ref_base(2'b01) + 28'(i) || log_data[i] !== offer_q[i]) begin
                n_bad++;
                $display("FAIL rstmid_l1_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], ref_base(2'b01) + 28'(i), offer_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        run_region(2'b01, 256, 0, 1, 1'b0, 100, -1);
        n_vec++; if (timeout) begin n_bad++; $display("FAIL ignore_timeout: got no done within %0d cycles, want done", MAX_CYC); end
        n_vec++; if (log_addr.size() != 256) begin n_bad++; $display("FAIL ignore_count: got %0d writes want 256", log_addr.size()); end
        for (int i = 0; i < log_addr.size() && i < 256; i++) begin
            n_vec++;
            if (log_addr[i] !== ref_base(2'b01) + 28'(i) || log_data[i] !== offer_q[i]) begin
                n_bad++;
                $display("FAIL ignore_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], ref_base(2'b01) + 28'(i), offer_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL ignore_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL ignore_busy_after: got %b want 0", busy_after); end
    endtask

    initial begin
        test_reset();
        test_image();
        test_l2_toggle();
        test_l0_stall();
        test_l1_overflow();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_writer.md
SDRAM_WRITER -- requirements
Module: sdram_writer

Interface
REQ-001 SHALL have parameter MASTER_ADDRESSWIDTH, default 28, Avalon master address width.
REQ-002 SHALL have parameter DATAWIDTH, default 8, byte-wide write data.
REQ-003 SHALL have parameter SDRAM_ADDR, default 32'h08000000, SDRAM base address.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth (power of two).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a region write.
REQ-009 SHALL have port which_data  in  2  region: 00 L0, 01 L1, 10 L2, 11 image.
REQ-010 SHALL have port in_data  in  8  source byte.
REQ-011 SHALL have port in_valid  in  1  in_data valid.
REQ-012 SHALL have port in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-013 SHALL have port busy  out  1  high from start acceptance until done.
REQ-014 SHALL have port done  out  1  one-cycle pulse after the last write completes.
REQ-015 SHALL have port master_address  out  MASTER_ADDRESSWIDTH  Avalon write address.
REQ-016 SHALL have port master_writedata  out  DATAWIDTH  Avalon write data.
REQ-017 SHALL have port master_write  out  1  Avalon write strobe.
REQ-018 SHALL have port master_read  out  1  tied 0.
REQ-019 SHALL have port master_waitrequest  in  1  slave stall.

Function
REQ-020 SHALL implement states IDLE, WRITE, DONE: IDLE->WRITE on start; WRITE->DONE when written count equals region length; DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL, on start in IDLE, latch base/length: image SDRAM_ADDR/128; L0 +0x080/2048; L1 +0x880/256; L2 +0x980/160.
REQ-022 SHALL ignore start while in WRITE or DONE.
REQ-023 SHALL drive in_ready = (state==WRITE) && FIFO not full && accepted count < length; no bytes beyond length are accepted.
REQ-024 SHALL push an accepted byte into the FIFO registered; earliest appearance on master_writedata is the following cycle (empty-FIFO push/pop does not bypass).
REQ-025 SHALL assert master_write in WRITE whenever the FIFO is non-empty, with master_address = base + written count and master_writedata = FIFO head.
REQ-026 SHALL pop the FIFO and increment written count only on master_write && !master_waitrequest.
REQ-027 SHALL hold master_address, master_writedata and master_write stable while master_waitrequest is high.
REQ-028 SHALL allow a simultaneous push and pop in one cycle when FIFO is neither full nor empty; occupancy unchanged.
REQ-029 SHALL use 12-bit accepted/written counters; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-030 SHALL drive master_address = 0 when master_write is low.
REQ-031 SHALL assert busy in WRITE and DONE, deasserted in IDLE; done high only in DONE.

Reset
REQ-032 SHALL on reset: state IDLE, counters 0, FIFO empty, in_ready 0, busy 0, done 0, master_write 0, master_address 0, master_writedata 0.
REQ-033 SHALL abandon an in-progress region on reset mid-operation; no further writes after the reset edge.

Structure
REQ-034 SHALL place the state enum, region base offsets and region sizes (128, 2048, 256, 160) in shared package sdram_pkg, also used by the reader.
REQ-035 SHALL implement the input buffer as sub-module byte_fifo (push/pop/full/empty/head).

Verification
REQ-036 Image, waitrequest 0, bytes 0..127 continuous -> 128 writes at 0x08000000..0x0800007F, data = index, one done pulse, busy low after.
REQ-037 L2, waitrequest toggling every cycle -> 160 writes at 0x08000980..0x08000A1F, address/data stable during stall, no duplicate or skipped addresses.
REQ-038 L0, waitrequest held high 10 cycles with in_valid high -> in_ready low after 4 bytes buffered; resumes on release, data order preserved.
REQ-039 L1, 300 bytes offered -> exactly 256 accepted, in_ready low after byte 256, last write at 0x0800097F.
REQ-040 Reset asserted during L0 at written count 1000 -> master_write 0 and busy 0 next cycle; subsequent L1 start writes from 0x08000880.
REQ-041 start pulsed with which_data=11 during L1 write -> ignored; L1 completes normally with single done.
